// File: rtl/int_exec_arbiter.sv
// int_exec_arbiter
//   Shares one integer execution datapath (ALU / branch compare / address
//   generation) between two issue sources: requester 0 (integer reservation
//   station) and requester 1 (load/store AGU queue). At most one requester is
//   granted per cycle. Its operation is executed combinationally and captured
//   in a single output register with a valid/ready handshake toward writeback.
//
// Configuration macro:
//   INT_EXEC_ARB_RR_EN  defined   -> round-robin between the two requesters
//                       undefined -> fixed priority, requester 0 wins
//
// Ports:
//   clk, reset (sync, active-high), flush (same-cycle kill)
//   reqN_valid / reqN_ready            issue handshake, N = 0,1
//   reqN_rs1_data, reqN_rs2_data, reqN_imm_data   32-bit operands
//   reqN_funct3, reqN_funct7, reqN_kind           operation selectors
//   reqN_tag                                      destination tag
//   out_valid / out_ready              result handshake
//   out_result, out_tag, out_src       registered result, tag, source index
module int_exec_arbiter #(
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_rs1_data,
  input  logic [31:0]      req0_rs2_data,
  input  logic [31:0]      req0_imm_data,
  input  logic [2:0]       req0_funct3,
  input  logic [6:0]       req0_funct7,
  input  logic [2:0]       req0_kind,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_rs1_data,
  input  logic [31:0]      req1_rs2_data,
  input  logic [31:0]      req1_imm_data,
  input  logic [2:0]       req1_funct3,
  input  logic [6:0]       req1_funct7,
  input  logic [2:0]       req1_kind,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_src
);

  localparam int DATA_W = 32;

  localparam logic [2:0] KIND_OP     = 3'd0;
  localparam logic [2:0] KIND_OP_IMM = 3'd1;
  localparam logic [2:0] KIND_STORE  = 3'd2;
  localparam logic [2:0] KIND_LOAD   = 3'd3;
  localparam logic [2:0] KIND_BRANCH = 3'd4;

  // ALU decoded from {funct7, funct3}; unlisted encodings return 0.
  function automatic logic [DATA_W-1:0] alu_op(
    input logic [6:0]               f7,
    input logic [2:0]               f3,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic [4:0]        sh;
    logic [DATA_W-1:0] r;
    sh = b[4:0];
    r  = '0;
    case ({f7, f3})
      10'b0000000_000: r = a + b;
      10'b0100000_000: r = a - b;
      10'b0000000_001: r = a << sh;
      10'b0000000_010: r = {{(DATA_W-1){1'b0}}, (a < b)};
      10'b0000000_011: r = {{(DATA_W-1){1'b0}}, ($unsigned(a) < $unsigned(b))};
      10'b0000000_100: r = a ^ b;
      10'b0000000_101: r = $unsigned(a) >> sh;
      10'b0100000_101: r = a >>> sh;
      10'b0000000_110: r = a | b;
      10'b0000000_111: r = a & b;
      default:         r = '0;
    endcase
    return r;
  endfunction

  function automatic logic branch_cmp(
    input logic [2:0]               f3,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    logic t;
    case (f3)
      3'b000:  t = (a == b);
      3'b001:  t = (a != b);
      3'b100:  t = (a < b);
      3'b101:  t = (a >= b);
      3'b110:  t = ($unsigned(a) < $unsigned(b));
      3'b111:  t = ($unsigned(a) >= $unsigned(b));
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  logic                     vld_p1;
  logic [DATA_W-1:0]        result_p1;
  logic [TAG_W-1:0]         tag_p1;
  logic                     src_p1;

  logic                     grant0;
  logic                     grant1;
  logic                     can_accept;
  logic                     take;
  logic                     xfer;

  logic signed [DATA_W-1:0] rs1_p0;
  logic signed [DATA_W-1:0] rs2_p0;
  logic signed [DATA_W-1:0] imm_p0;
  logic signed [DATA_W-1:0] op2_p0;
  logic [2:0]               f3_p0;
  logic [6:0]               f7_p0;
  logic [2:0]               kind_p0;
  logic [TAG_W-1:0]         tag_p0;
  logic [DATA_W-1:0]        result_p0;

  // ---- stage p0: arbitration, operand select, execute ----
`ifdef INT_EXEC_ARB_RR_EN
  logic last_grant;
  // On contention the requester that did not win the last transfer goes next.
  assign grant1 = req1_valid && (!req0_valid || !last_grant);
`else
  assign grant1 = req1_valid && !req0_valid;
`endif
  assign grant0 = req0_valid && !grant1;

  // Ready never looks at operand data, only at the handshake state.
  assign can_accept = !vld_p1 || out_ready;
  assign take       = can_accept && !flush && !reset;
  assign req0_ready = grant0 && take;
  assign req1_ready = grant1 && take;
  assign xfer       = req0_ready || req1_ready;

  always_comb begin
    rs1_p0  = grant1 ? req1_rs1_data : req0_rs1_data;
    rs2_p0  = grant1 ? req1_rs2_data : req0_rs2_data;
    imm_p0  = grant1 ? req1_imm_data : req0_imm_data;
    f3_p0   = grant1 ? req1_funct3   : req0_funct3;
    f7_p0   = grant1 ? req1_funct7   : req0_funct7;
    kind_p0 = grant1 ? req1_kind     : req0_kind;
    tag_p0  = grant1 ? req1_tag      : req0_tag;

    op2_p0 = (kind_p0 == KIND_OP_IMM || kind_p0 == KIND_LOAD ||
              kind_p0 == KIND_STORE) ? imm_p0 : rs2_p0;

    case (kind_p0)
      KIND_OP, KIND_OP_IMM:  result_p0 = alu_op(f7_p0, f3_p0, rs1_p0, op2_p0);
      KIND_LOAD, KIND_STORE: result_p0 = rs1_p0 + op2_p0;
      KIND_BRANCH:           result_p0 = {{(DATA_W-1){1'b0}},
                                          branch_cmp(f3_p0, rs1_p0, op2_p0)};
      default:               result_p0 = '0;
    endcase
  end

  // ---- stage p1: output register ----
  // A transfer overwrites the register even while the consumer takes the old
  // value, so back-to-back results stream at one per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      tag_p1    <= '0;
      src_p1    <= 1'b0;
    end else if (xfer) begin
      vld_p1    <= 1'b1;
      result_p1 <= result_p0;
      tag_p1    <= tag_p0;
      src_p1    <= grant1;
    end else if (flush || out_ready) begin
      vld_p1    <= 1'b0;
    end
  end

`ifdef INT_EXEC_ARB_RR_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant1;
    end
  end
`endif

  assign out_valid  = vld_p1;
  assign out_result = result_p1;
  assign out_tag    = tag_p1;
  assign out_src    = src_p1;

endmodule
